// File: rtl/memory_sync.sv
`default_nettype none
// ============================================================================
// Module      : memory_sync
// Description : Single-clock synchronous RAM, DEPTH = 2^ADDR_W words of
//               DATA_W bits, with per-nibble write mask, configurable read
//               latency (1 or 2) and configurable same-address
//               read-during-write behaviour. After every reset the whole
//               array is cleared to zero, one word per cycle. Requests
//               issued while clearing are dropped.
// Ports       : clk_i       - clock, all state changes on rising edge
//               rst_i       - synchronous active-high reset
//               rd_req_i    - read request
//               rd_addr_i   - read address
//               wr_en_i     - write request
//               wr_addr_i   - write address
//               wr_data_i   - write data
//               wr_mask_i   - per-nibble write enable (bit i -> nibble i)
//               q_o         - registered read data
//               rd_valid_o  - one-cycle pulse, q_o holds a completed read
//               busy_o      - high during reset or memory clearing
// Revision    : 1.0 - initial release
// ============================================================================
module memory_sync #(
    parameter int DATA_W   = 20,
    parameter int ADDR_W   = 5,
    parameter int RD_LAT   = 1,
    parameter int WR_FIRST = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                rd_req_i,
    input  logic [ADDR_W-1:0]   rd_addr_i,
    input  logic                wr_en_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    input  logic [DATA_W-1:0]   wr_data_i,
    input  logic [DATA_W/4-1:0] wr_mask_i,
    output logic [DATA_W-1:0]   q_o,
    output logic                rd_valid_o,
    output logic                busy_o
);

    localparam int              c_DEPTH     = 1 << ADDR_W;
    localparam int              c_NIB       = DATA_W / 4;
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(c_DEPTH - 1);

    typedef enum logic [0:0] {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   init_cnt_q;
    logic [DATA_W-1:0]   mem_q [c_DEPTH];

    logic [DATA_W-1:0]   q_q;
    logic                rd_valid_q;

    logic                ready;
    logic                rd_fire;
    logic                wr_fire;
    logic [DATA_W-1:0]   wr_old;
    logic [DATA_W-1:0]   wr_merged;
    logic [DATA_W-1:0]   rd_word;

    // ------------------------------------------------------------------
    // Init / ready FSM. Clearing walks init_cnt from 0 to DEPTH-1; the
    // edge that clears the last word also moves to READY.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
        end else if (state_q == S_INIT) begin
            init_cnt_q <= init_cnt_q + 1'b1;
            if (init_cnt_q == c_LAST_ADDR) begin
                state_q <= S_READY;
            end
        end
    end

    // Reset is OR-ed in so busy rises in the same cycle reset is applied.
    assign busy_o  = (state_q == S_INIT) | rst_i;

    assign ready   = (state_q == S_READY) & ~rst_i;
    assign rd_fire = rd_req_i & ready;
    assign wr_fire = wr_en_i & ready;

    // ------------------------------------------------------------------
    // Masked merge: unmasked nibbles keep the currently stored value.
    // ------------------------------------------------------------------
    assign wr_old = mem_q[wr_addr_i];

    for (genvar i = 0; i < c_NIB; i++) begin : g_nibble
        assign wr_merged[4*i +: 4] = wr_mask_i[i] ? wr_data_i[4*i +: 4]
                                                  : wr_old[4*i +: 4];
    end

    // ------------------------------------------------------------------
    // Read word selection for a read and write landing on the same edge.
    // The array itself always holds the pre-write word at this point, so
    // only the write-first variant needs a bypass from the merge path.
    // ------------------------------------------------------------------
    if (WR_FIRST != 0) begin : g_new_data
        assign rd_word = (wr_fire && (wr_addr_i == rd_addr_i)) ? wr_merged
                                                               : mem_q[rd_addr_i];
    end else begin : g_old_data
        assign rd_word = mem_q[rd_addr_i];
    end

    // ------------------------------------------------------------------
    // Storage array. No write of any kind on a reset edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_q == S_INIT) begin
                mem_q[init_cnt_q] <= '0;
            end else if (wr_fire) begin
                mem_q[wr_addr_i] <= wr_merged;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline. q holds its value whenever no result is delivered.
    // ------------------------------------------------------------------
    if (RD_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] pipe_data_q;
        logic              pipe_vld_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                pipe_vld_q  <= 1'b0;
                pipe_data_q <= '0;
                rd_valid_q  <= 1'b0;
                q_q         <= '0;
            end else begin
                pipe_vld_q <= rd_fire;
                if (rd_fire) begin
                    pipe_data_q <= rd_word;
                end
                rd_valid_q <= pipe_vld_q;
                if (pipe_vld_q) begin
                    q_q <= pipe_data_q;
                end
            end
        end
    end else begin : g_lat1
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                rd_valid_q <= 1'b0;
                q_q        <= '0;
            end else begin
                rd_valid_q <= rd_fire;
                if (rd_fire) begin
                    q_q <= rd_word;
                end
            end
        end
    end

    assign q_o        = q_q;
    assign rd_valid_o = rd_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_sync
// Description : Scoreboard bench for memory_sync. Two instances share the
//               same stimulus: dutA uses RD_LAT=1/WR_FIRST=0, dutB uses
//               RD_LAT=2/WR_FIRST=1. Each read pushes a hand-computed
//               expected word and due cycle per instance; a monitor pops
//               and compares on rd_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_sync;

    typedef struct {
        logic [19:0] data;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        rd_req;
    logic [4:0]  rd_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [19:0] wr_data;
    logic [4:0]  wr_mask;

    logic [19:0] q_a, q_b;
    logic        vld_a, vld_b;
    logic        busy_a, busy_b;

    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 0;
    exp_t        sb [2][$];
    logic [19:0] hold [2];

    memory_sync #(.DATA_W(20), .ADDR_W(5), .RD_LAT(1), .WR_FIRST(0)) u_dut_a (
        .clk_i(clk), .rst_i(rst),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_mask_i(wr_mask),
        .q_o(q_a), .rd_valid_o(vld_a), .busy_o(busy_a)
    );

    memory_sync #(.DATA_W(20), .ADDR_W(5), .RD_LAT(2), .WR_FIRST(1)) u_dut_b (
        .clk_i(clk), .rst_i(rst),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_mask_i(wr_mask),
        .q_o(q_b), .rd_valid_o(vld_b), .busy_o(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Monitor: compares on rd_valid, flags overdue/unexpected results and
    // checks that q holds between results.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                logic        v;
                logic [19:0] qq;
                string       nm;
                exp_t        e;
                v  = (d == 0) ? vld_a : vld_b;
                qq = (d == 0) ? q_a : q_b;
                nm = (d == 0) ? "dutA" : "dutB";
                while (sb[d].size() > 0 && sb[d][0].due < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s missing_rd_valid: no pulse, required data %05h at cycle %0d",
                             nm, sb[d][0].data, sb[d][0].due);
                    void'(sb[d].pop_front());
                end
                checks++;
                if (v) begin
                    if (sb[d].size() == 0) begin
                        errors++;
                        $display("FAIL %s unexpected_rd_valid: q=%05h at cycle %0d, required no pulse",
                                 nm, qq, cyc);
                    end else begin
                        e = sb[d].pop_front();
                        if (e.due != cyc || qq !== e.data) begin
                            errors++;
                            $display("FAIL %s read_data: got %05h at cycle %0d, required %05h at cycle %0d",
                                     nm, qq, cyc, e.data, e.due);
                        end
                        hold[d] = e.data;
                    end
                end else if (qq !== hold[d]) begin
                    errors++;
                    $display("FAIL %s q_hold: got %05h at cycle %0d, required %05h",
                             nm, qq, cyc, hold[d]);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // One clock of stimulus; ea/eb are the expected words for dutA/dutB.
    task automatic step(input bit do_rd, input logic [4:0] ra,
                        input logic [19:0] ea, input logic [19:0] eb,
                        input bit do_wr, input logic [4:0] wa,
                        input logic [19:0] wd, input logic [4:0] wm);
        rd_req  = do_rd;
        rd_addr = ra;
        wr_en   = do_wr;
        wr_addr = wa;
        wr_data = wd;
        wr_mask = wm;
        if (do_rd) begin
            sb[0].push_back('{ea, cyc + 1});
            sb[1].push_back('{eb, cyc + 2});
        end
        tick();
        rd_req = 1'b0;
        wr_en  = 1'b0;
    endtask

    // Counts cycles with busy high, bounded so a stuck busy cannot hang.
    task automatic count_busy(output int na, output int nb);
        na = 0;
        nb = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy_a && !busy_b) break;
            if (busy_a) na++;
            if (busy_b) nb++;
            tick();
        end
    endtask

    initial begin
        int na, nb;
        rst = 1'b1; rd_req = 1'b0; rd_addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
        hold[0] = '0;
        hold[1] = '0;

        // Reset state
        tick();
        mon_en = 1'b1;
        chk("reset_busy_a", 32'(busy_a), 1);
        chk("reset_busy_b", 32'(busy_b), 1);
        chk("reset_q_a", 32'(q_a), 0);
        chk("reset_q_b", 32'(q_b), 0);
        chk("reset_vld_a", 32'(vld_a), 0);
        chk("reset_vld_b", 32'(vld_b), 0);
        tick();

        // Release with requests held during clearing: they must be dropped
        rst = 1'b0;
        rd_req = 1'b1; rd_addr = 5'd5;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 20'hFFFFF; wr_mask = 5'h1F;
        count_busy(na, nb);
        rd_req = 1'b0; wr_en = 1'b0;
        chk("init_busy_cycles_a", 32'(na), 32);
        chk("init_busy_cycles_b", 32'(nb), 32);

        // Whole array reads back zero, back-to-back
        for (int a = 0; a < 32; a++) step(1, 5'(a), 20'h0, 20'h0, 0, 0, 0, 0);

        // Full then partial masked write, then all-zero mask
        step(0, 0, 0, 0, 1, 5'd3, 20'hABCDE, 5'b11111);
        step(1, 5'd3, 20'hABCDE, 20'hABCDE, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 5'd3, 20'h12345, 5'b00011);
        step(1, 5'd3, 20'hABC45, 20'hABC45, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 5'd3, 20'hFFFFF, 5'b00000);
        step(1, 5'd3, 20'hABC45, 20'hABC45, 0, 0, 0, 0);

        // Same-edge read/write collision, then read right after write
        step(0, 0, 0, 0, 1, 5'd7, 20'h11111, 5'b11111);
        step(1, 5'd7, 20'h11111, 20'h22222, 1, 5'd7, 20'h22222, 5'b11111);
        step(1, 5'd7, 20'h22222, 20'h22222, 0, 0, 0, 0);
        step(1, 5'd7, 20'h22222, 20'h22322, 1, 5'd7, 20'h33333, 5'b00100);
        step(1, 5'd7, 20'h22322, 20'h22322, 0, 0, 0, 0);

        // Read and write to different addresses on the same edge
        step(1, 5'd3, 20'hABC45, 20'hABC45, 1, 5'd8, 20'h55555, 5'b11111);
        step(1, 5'd8, 20'h55555, 20'h55555, 0, 0, 0, 0);

        // Pipelined back-to-back reads of preloaded words
        step(0, 0, 0, 0, 1, 5'd0, 20'h00010, 5'b11111);
        step(0, 0, 0, 0, 1, 5'd1, 20'h00020, 5'b11111);
        step(0, 0, 0, 0, 1, 5'd2, 20'h00030, 5'b11111);
        step(1, 5'd0, 20'h00010, 20'h00010, 0, 0, 0, 0);
        step(1, 5'd1, 20'h00020, 20'h00020, 0, 0, 0, 0);
        step(1, 5'd2, 20'h00030, 20'h00030, 0, 0, 0, 0);
        repeat (3) tick();

        // Reset while a dutB read is in flight: result is discarded
        step(1, 5'd3, 20'hABC45, 20'hABC45, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        sb[0].delete();
        sb[1].delete();
        hold[0] = '0;
        hold[1] = '0;
        chk("flush_q_a", 32'(q_a), 0);
        chk("flush_q_b", 32'(q_b), 0);
        chk("flush_vld_b", 32'(vld_b), 0);

        // Reset pulsed mid-clear restarts the full clear
        rst = 1'b0;
        repeat (10) tick();
        chk("mid_init_busy", 32'(busy_a), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_busy(na, nb);
        chk("restart_busy_cycles_a", 32'(na), 32);
        chk("restart_busy_cycles_b", 32'(nb), 32);

        // Contents written before the reset are gone
        step(1, 5'd3, 20'h0, 20'h0, 0, 0, 0, 0);
        step(1, 5'd7, 20'h0, 20'h0, 0, 0, 0, 0);
        step(1, 5'd1, 20'h0, 20'h0, 0, 0, 0, 0);
        repeat (4) tick();

        chk("scoreboard_drained_a", 32'(sb[0].size()), 0);
        chk("scoreboard_drained_b", 32'(sb[1].size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memory_sync.md
MEMORY_SYNC -- requirements
Module: memory_sync

Interface
Parameters:
REQ-001 The block SHALL have parameter DATA_W, default 20, word width in bits, a multiple of 4.
REQ-002 The block SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2^ADDR_W words.
REQ-003 The block SHALL have parameter RD_LAT, default 1, read latency in cycles; legal values 1 or 2.
REQ-004 The block SHALL have parameter WR_FIRST, default 0; 0 = same-address read during write returns old data, 1 = returns new (merged) data.

Ports:
REQ-005 Clock  in  1  single clock; all state changes on rising edge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 rd_req  in  1  read request, sampled each rising edge.
REQ-008 rd_addr  in  ADDR_W  read address.
REQ-009 wr_en  in  1  write request, sampled each rising edge.
REQ-010 wr_addr  in  ADDR_W  write address.
REQ-011 wr_data  in  DATA_W  write data.
REQ-012 wr_mask  in  DATA_W/4  per-nibble write enable; bit i covers wr_data[4i+3:4i].
REQ-013 q  out  DATA_W  registered read data.
REQ-014 rd_valid  out  1  one-cycle pulse: q holds the data for a completed read.
REQ-015 busy  out  1  high while Reset is high or initialisation is in progress.

Function
REQ-016 The block SHALL implement a two-state FSM: INIT (clearing memory) and READY.
REQ-017 In INIT, one word per cycle SHALL be written to zero at address init_cnt, starting at 0 and incrementing by 1.
REQ-018 On the edge that clears address DEPTH-1, the FSM SHALL go to READY; INIT lasts exactly DEPTH cycles after Reset deasserts.
REQ-019 busy SHALL equal (state == INIT) OR Reset.
REQ-020 In INIT, rd_req and wr_en SHALL be ignored: no memory update, no rd_valid, requests dropped, not queued.
REQ-021 In READY with wr_en=1, nibbles with wr_mask[i]=1 SHALL be written at wr_addr; other nibbles are unchanged; wr_mask all-zero SHALL leave memory unchanged.
REQ-022 In READY with rd_req=1 sampled at edge N: for RD_LAT=1, q SHALL update and rd_valid SHALL be 1 after edge N; for RD_LAT=2, after edge N+1.
REQ-023 With RD_LAT=2, back-to-back reads SHALL be fully pipelined: one result per cycle, in request order.
REQ-024 q SHALL hold its last value when rd_valid=0.
REQ-025 For a read and a write to the same address at the same edge, q SHALL return the pre-write word if WR_FIRST=0, or the post-write masked merge if WR_FIRST=1.
REQ-026 A read and a write to different addresses at the same edge SHALL both complete without interaction.
REQ-027 A read issued at the edge after a write to the same address SHALL return the written data, for both WR_FIRST values.
REQ-028 Addresses SHALL be used modulo DEPTH; no out-of-range condition exists.

Reset
REQ-029 At any rising edge with Reset=1: state SHALL go to INIT, init_cnt to 0, q to 0, rd_valid and all read-pipeline valid bits to 0; no clearing write occurs during that cycle.
REQ-030 Reset asserted mid-INIT SHALL restart clearing from address 0.
REQ-031 Reset asserted in READY SHALL discard in-flight reads (no rd_valid afterwards) and re-clear the whole memory.
REQ-032 The first clearing write SHALL occur at the first rising edge after Reset deasserts.

Verification
REQ-033 Default parameters: Reset for 2 cycles, then release -> busy=1 for exactly 32 cycles, then 0; reading any address returns 0.
REQ-034 Write 0xABCDE to address 3 with mask 0b11111, then read address 3 with mask-partial write 0x12345 mask 0b00011 -> second read returns 0xABC45.
REQ-035 WR_FIRST=0 vs 1: memory[7]=0x11111; same-edge write 0x22222 (full mask) and read of address 7 -> q=0x11111 or 0x22222 respectively; next read of address 7 returns 0x22222 in both.
REQ-036 RD_LAT=2: reads of addresses 0,1,2 on three consecutive edges (memory preloaded with 0x00010,0x00020,0x00030) -> rd_valid high for 3 consecutive cycles starting 2 edges after the first request, q=0x00010,0x00020,0x00030.
REQ-037 rd_req and wr_en held high during INIT -> no rd_valid pulse, and memory reads back all-zero after READY.
REQ-038 Reset pulsed at INIT cycle 10 -> busy stays high for 32 more cycles after release; a read in flight when Reset is pulsed in READY produces no rd_valid, and q=0.
